// File: rtl/prf_bypass_if.sv
// Bundle of writeback, rename-allocation and operand-read signals for the
// physical register file. The master drives requests and the slave is the register file.
interface prf_bypass_if #(
  parameter int XLEN       = 32,
  parameter int N_PHYS_REG = 64,
  parameter int N_WR       = 7,
  parameter int N_RD       = 6,
  parameter int N_ALLOC    = 2
);
  localparam int PREG_W = $clog2(N_PHYS_REG);

  logic [N_WR-1:0]                 wr_en;
  logic [N_WR-1:0][PREG_W-1:0]     wr_idx;
  logic [N_WR-1:0][XLEN-1:0]       wr_data;
  logic [N_ALLOC-1:0]              alloc_en;
  logic [N_ALLOC-1:0][PREG_W-1:0]  alloc_idx;
  logic [N_RD-1:0][PREG_W-1:0]     rd_idx;
  logic [N_RD-1:0][XLEN-1:0]       rd_data;
  logic [N_RD-1:0]                 rd_ready;
  logic [N_PHYS_REG-1:0]           ready_vec;
  logic                            conflict_err;

  modport master (
    output wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rd_idx,
    input  rd_data, rd_ready, ready_vec, conflict_err
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rd_idx,
    output rd_data, rd_ready, ready_vec, conflict_err
  );
endinterface

// File: rtl/prf_bypass.sv
// Physical register file with multi-port writeback, same-cycle write bypass on reads,
// per-register ready bits cleared by rename allocation, and a hardwired zero register.
module prf_bypass #(
  parameter  int XLEN       = 32,
  parameter  int N_PHYS_REG = 64,
  parameter  int N_WR       = 7,
  parameter  int N_RD       = 6,
  parameter  int N_ALLOC    = 2,
  localparam int PREG_W     = $clog2(N_PHYS_REG)
) (
  input  logic          clock,
  input  logic          reset,
  prf_bypass_if.slave   bus
);

  logic [XLEN-1:0] stored_value [N_PHYS_REG];
  logic            conflict_reg;
  logic            conflict_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_PHYS_REG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign stored_value[gi] = '0;
        assign bus.ready_vec[gi] = 1'b1;
      end else begin : g_live
        logic [XLEN-1:0] value_reg;
        logic            ready_reg;
        logic            wr_hit;
        logic [XLEN-1:0] wr_win;
        logic            alloc_hit;

        // Ascending scan: the highest-numbered matching port overrides earlier ones.
        always_comb begin
          wr_hit = 1'b0;
          wr_win = '0;
          for (int p = 0; p < N_WR; p++) begin
            if (bus.wr_en[p] && bus.wr_idx[p] == PREG_W'(gi)) begin
              wr_hit = 1'b1;
              wr_win = bus.wr_data[p];
            end
          end
        end

        always_comb begin
          alloc_hit = 1'b0;
          for (int a = 0; a < N_ALLOC; a++) begin
            if (bus.alloc_en[a] && bus.alloc_idx[a] == PREG_W'(gi)) begin
              alloc_hit = 1'b1;
            end
          end
        end

        // Allocation takes priority over writeback for the ready bit.
        always_ff @(posedge clock) begin
          if (reset) begin
            value_reg <= '0;
            ready_reg <= 1'b1;
          end else begin
            if (wr_hit) begin
              value_reg <= wr_win;
            end
            if (alloc_hit) begin
              ready_reg <= 1'b0;
            end else if (wr_hit) begin
              ready_reg <= 1'b1;
            end
          end
        end

        assign stored_value[gi]  = value_reg;
        assign bus.ready_vec[gi] = ready_reg;
      end
    end

    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic            byp_hit;
      logic [XLEN-1:0] byp_data;

      always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int p = 0; p < N_WR; p++) begin
          if (bus.wr_en[p] && bus.wr_idx[p] == bus.rd_idx[gi]) begin
            byp_hit  = 1'b1;
            byp_data = bus.wr_data[p];
          end
        end
      end

      always_comb begin
        bus.rd_data[gi]  = stored_value[bus.rd_idx[gi]];
        bus.rd_ready[gi] = bus.ready_vec[bus.rd_idx[gi]];
        if (bus.rd_idx[gi] == '0) begin
          bus.rd_data[gi]  = '0;
          bus.rd_ready[gi] = 1'b1;
        end else if (byp_hit) begin
          bus.rd_data[gi]  = byp_data;
          bus.rd_ready[gi] = 1'b1;
        end
      end
    end
  endgenerate

  // Any pair of enabled writes aimed at the same nonzero register is a conflict.
  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < N_WR; i++) begin
      for (int j = i + 1; j < N_WR; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && bus.wr_idx[i] == bus.wr_idx[j]
            && bus.wr_idx[i] != '0) begin
          conflict_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_reg <= 1'b0;
    end else begin
      conflict_reg <= conflict_next;
    end
  end

  assign bus.conflict_err = conflict_reg;

endmodule

// File: tb/tb_prf_bypass.sv
// Directed-vector bench for prf_bypass: reset, alloc/bypass, write conflicts,
// zero register, alloc-write overlap, reset priority and full-width writeback.
module tb_prf_bypass;
  localparam int XLEN       = 32;
  localparam int N_PHYS_REG = 64;
  localparam int N_WR       = 7;
  localparam int N_RD       = 6;
  localparam int N_ALLOC    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  prf_bypass_if #(.XLEN(XLEN), .N_PHYS_REG(N_PHYS_REG), .N_WR(N_WR),
                  .N_RD(N_RD), .N_ALLOC(N_ALLOC)) bus ();

  prf_bypass #(.XLEN(XLEN), .N_PHYS_REG(N_PHYS_REG), .N_WR(N_WR),
               .N_RD(N_RD), .N_ALLOC(N_ALLOC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_writes();
    bus.wr_en     = '0;
    bus.wr_idx    = '0;
    bus.wr_data   = '0;
    bus.alloc_en  = '0;
    bus.alloc_idx = '0;
  endtask

  task automatic test_reset();
    clear_writes();
    bus.rd_idx = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < N_RD; k++) bus.rd_idx[k] = 6'd5;
    #1;
    for (int k = 0; k < N_RD; k++) begin
      checks++;
      if (bus.rd_data[k] !== 32'h0 || bus.rd_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_read port %0d: got data %h ready %b, want 0 ready 1",
                 k, bus.rd_data[k], bus.rd_ready[k]);
      end
    end
    checks++;
    if (bus.ready_vec !== {N_PHYS_REG{1'b1}} || bus.conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready_vec %h conflict %b, want all ones conflict 0",
               bus.ready_vec, bus.conflict_err);
    end
    $display("reset: checked idx 5 on all ports, ready_vec, conflict_err");
  endtask

  task automatic test_alloc_bypass();
    clear_writes();
    bus.alloc_en[0]  = 1'b1;
    bus.alloc_idx[0] = 6'd9;
    cycle();
    clear_writes();
    bus.rd_idx[0] = 6'd9;
    #1;
    checks++;
    if (bus.rd_ready[0] !== 1'b0 || bus.ready_vec[9] !== 1'b0) begin
      errors++;
      $display("FAIL alloc_ready: got rd_ready %b ready_vec[9] %b, want 0 0",
               bus.rd_ready[0], bus.ready_vec[9]);
    end
    bus.wr_en[3]   = 1'b1;
    bus.wr_idx[3]  = 6'd9;
    bus.wr_data[3] = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hDEADBEEF || bus.rd_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_read: got data %h ready %b, want deadbeef ready 1",
               bus.rd_data[0], bus.rd_ready[0]);
    end
    cycle();
    clear_writes();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hDEADBEEF || bus.rd_ready[0] !== 1'b1 || bus.ready_vec[9] !== 1'b1) begin
      errors++;
      $display("FAIL stored_read: got data %h ready %b ready_vec[9] %b, want deadbeef 1 1",
               bus.rd_data[0], bus.rd_ready[0], bus.ready_vec[9]);
    end
    $display("alloc_bypass: alloc 9, bypass write deadbeef, storage read");
  endtask

  task automatic test_conflict();
    clear_writes();
    bus.wr_en[1] = 1'b1; bus.wr_idx[1] = 6'd12; bus.wr_data[1] = 32'h11;
    bus.wr_en[6] = 1'b1; bus.wr_idx[6] = 6'd12; bus.wr_data[6] = 32'h66;
    bus.rd_idx[2] = 6'd12;
    #1;
    checks++;
    if (bus.rd_data[2] !== 32'h66 || bus.conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL conflict_bypass: got data %h conflict %b, want 66 conflict 0",
               bus.rd_data[2], bus.conflict_err);
    end
    cycle();
    clear_writes();
    #1;
    checks++;
    if (bus.rd_data[2] !== 32'h66 || bus.conflict_err !== 1'b1) begin
      errors++;
      $display("FAIL conflict_pulse: got data %h conflict %b, want 66 conflict 1",
               bus.rd_data[2], bus.conflict_err);
    end
    cycle();
    checks++;
    if (bus.conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL conflict_clear: got conflict %b, want 0", bus.conflict_err);
    end
    $display("conflict: ports 1 and 6 to idx 12, port 6 wins, one-cycle pulse");
  endtask

  task automatic test_zero_reg();
    clear_writes();
    bus.wr_en[0] = 1'b1; bus.wr_idx[0] = 6'd0; bus.wr_data[0] = 32'hFFFF_FFFF;
    bus.wr_en[4] = 1'b1; bus.wr_idx[4] = 6'd0; bus.wr_data[4] = 32'h1234_5678;
    bus.alloc_en[0] = 1'b1; bus.alloc_idx[0] = 6'd0;
    bus.rd_idx[0] = 6'd0;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_bypass: got data %h ready %b, want 0 ready 1",
               bus.rd_data[0], bus.rd_ready[0]);
    end
    cycle();
    clear_writes();
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.ready_vec[0] !== 1'b1 || bus.conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_stored: got data %h ready_vec[0] %b conflict %b, want 0 1 0",
               bus.rd_data[0], bus.ready_vec[0], bus.conflict_err);
    end
    $display("zero_reg: writes and alloc to idx 0 ignored");
  endtask

  task automatic test_alloc_write();
    clear_writes();
    bus.alloc_en[1] = 1'b1; bus.alloc_idx[1] = 6'd20;
    bus.wr_en[2] = 1'b1; bus.wr_idx[2] = 6'd20; bus.wr_data[2] = 32'h1234;
    bus.rd_idx[1] = 6'd20;
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'h1234 || bus.rd_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL alloc_write_bypass: got data %h ready %b, want 1234 ready 1",
               bus.rd_data[1], bus.rd_ready[1]);
    end
    cycle();
    clear_writes();
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'h1234 || bus.rd_ready[1] !== 1'b0 || bus.ready_vec[20] !== 1'b0) begin
      errors++;
      $display("FAIL alloc_write_stored: got data %h ready %b ready_vec[20] %b, want 1234 0 0",
               bus.rd_data[1], bus.rd_ready[1], bus.ready_vec[20]);
    end
    $display("alloc_write: idx 20 value 1234 stored, ready held low");
  endtask

  task automatic test_reset_wins();
    clear_writes();
    bus.wr_en[5] = 1'b1; bus.wr_idx[5] = 6'd30; bus.wr_data[5] = 32'hAB;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clear_writes();
    bus.rd_idx[0] = 6'd30;
    bus.rd_idx[1] = 6'd20;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_wins_30: got data %h ready %b, want 0 ready 1",
               bus.rd_data[0], bus.rd_ready[0]);
    end
    checks++;
    if (bus.rd_data[1] !== 32'h0 || bus.rd_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_20: got data %h ready %b, want 0 ready 1",
               bus.rd_data[1], bus.rd_ready[1]);
    end
    $display("reset_wins: write to idx 30 under reset discarded");
  endtask

  task automatic test_all_ports();
    logic [XLEN-1:0] want;
    clear_writes();
    for (int p = 0; p < N_WR; p++) begin
      bus.wr_en[p]   = 1'b1;
      bus.wr_idx[p]  = 6'(p + 1);
      bus.wr_data[p] = 32'hA000_0100 + 32'(p);
    end
    cycle();
    clear_writes();
    for (int base = 1; base <= N_WR; base += N_RD) begin
      for (int k = 0; k < N_RD; k++) bus.rd_idx[k] = 6'((base + k) % 8);
      #1;
      for (int k = 0; k < N_RD; k++) begin
        if (base + k <= N_WR) begin
          want = 32'hA000_0100 + 32'(base + k - 1);
          checks++;
          if (bus.rd_data[k] !== want || bus.rd_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL all_ports idx %0d: got data %h ready %b, want %h ready 1",
                     base + k, bus.rd_data[k], bus.rd_ready[k], want);
          end
        end
      end
    end
    checks++;
    if (bus.conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL all_ports_conflict: got conflict %b, want 0", bus.conflict_err);
    end
    $display("all_ports: 7 distinct writes to idx 1..7 stored");
  endtask

  task automatic test_alloc_no_bypass();
    clear_writes();
    bus.alloc_en  = 2'b11;
    bus.alloc_idx[0] = 6'd3;
    bus.alloc_idx[1] = 6'd3;
    bus.rd_idx[0] = 6'd3;
    #1;
    checks++;
    if (bus.rd_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL alloc_no_bypass: got ready %b, want 1", bus.rd_ready[0]);
    end
    cycle();
    clear_writes();
    #1;
    checks++;
    if (bus.rd_ready[0] !== 1'b0 || bus.rd_data[0] !== 32'hA000_0102 || bus.conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL dup_alloc: got ready %b data %h conflict %b, want 0 a0000102 0",
               bus.rd_ready[0], bus.rd_data[0], bus.conflict_err);
    end
    $display("alloc_no_bypass: duplicate alloc idx 3, ready drops next cycle");
  endtask

  initial begin
    clear_writes();
    bus.rd_idx = '0;
    test_reset();
    test_alloc_bypass();
    test_conflict();
    test_zero_reg();
    test_alloc_write();
    test_reset_wins();
    test_all_ports();
    test_alloc_no_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
